rnd_share_sched: RTL and testbench
==================================

Name: rnd_share_sched

Overview:
- Time-shares one combinational rounding/overflow stage (Q-format reduce plus saturate) among N_CH filter channels of the DFE array.
- Each channel holds one pending accumulator word.
- A round-robin scheduler grants one word per cycle to the shared stage.
- The stage's result is registered, tagged with its channel ID, and each channel's saturation events are counted.

Parameters:
- N_CH, 4, number of requesting channels (2..8)
- ACC_WIDTH, 42, accumulator word width
- OUT_WIDTH, 16, rounded output width
- CNT_WIDTH, 16, width of per-channel saturation counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_data  in  N_CH*ACC_WIDTH  channel accumulator words; channel i in slice [i*ACC_WIDTH +: ACC_WIDTH]
- req_valid  in  N_CH  per-channel valid
- req_ready  out  N_CH  per-channel ready
- rnd_data_in  out  ACC_WIDTH  word sent to the shared rounding stage
- rnd_valid_in  out  1  valid to the shared rounding stage
- rnd_data_out  in  OUT_WIDTH  stage result, combinational
- rnd_ovf  in  1  stage overflow flag, combinational
- rnd_unf  in  1  stage underflow flag, combinational
- out_data  out  OUT_WIDTH  registered result
- out_valid  out  1  one-cycle pulse per result
- out_ch  out  $clog2(N_CH)  channel of out_data
- out_ovf  out  1  registered overflow flag
- out_unf  out  1  registered underflow flag
- cnt_clr  in  1  synchronous clear of all counters
- cnt_sel  in  $clog2(N_CH)  counter read select
- cnt_rdata  out  CNT_WIDTH  combinational read of selected counter

Behaviour:
- Reset (async, rst=1):
  - All hold registers empty; req_ready all 1.
  - RR pointer = 0; all counters = 0.
  - out_data = 0, out_valid = 0, out_ch = 0, out_ovf = 0, out_unf = 0.
  - rnd_valid_in = 0, rnd_data_in = 0.
  - Reset mid-operation discards pending words without producing output.
- Hold stage, per channel:
  - One-entry register plus full flag.
  - req_ready[i] = !full[i] | grant[i].
  - Transfer on req_valid[i] & req_ready[i] at the clock edge.
  - Grant and accept in the same cycle: the register is reloaded and stays full.
  - Grant without accept: the register empties.
- Arbiter:
  - Combinational. Candidates = full flags.
  - Grant goes to the first full channel at or after ptr, searching in increasing index with wrap-around.
  - At most one grant per cycle.
  - On a grant, ptr <= (granted + 1) mod N_CH. With no grant, ptr holds.
  - Starvation bound: a full channel is granted within N_CH cycles.
- Shared-stage drive:
  - rnd_data_in = hold[grant]; rnd_valid_in = any grant.
  - rnd_data_in = 0 when there is no grant.
- Output register:
  - On a grant edge: out_data <= rnd_data_out, out_ovf <= rnd_ovf, out_unf <= rnd_unf, out_ch <= grant index, out_valid <= 1.
  - With no grant: out_valid <= 0; out_data, out_ch and the flags hold.
  - No output backpressure; the consumer must accept every pulse.
- Latency:
  - A word accepted at edge E appears on out_* after edge E+1 when uncontended.
  - Worst case is edge E+N_CH.
- Throughput: one result per cycle total. Each channel can sustain 1 word/cycle only when alone.
- Counters:
  - cnt[i] increments on a registered result from ch i with ovf|unf.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - cnt_clr=1 zeroes all counters and wins over a simultaneous increment.
- Ordering: results per channel leave in arrival order, guaranteed by the single hold entry.

Optional Feature:
- Macro RND_SHARE_CH0_PRIO_EN.
- When defined:
  - Channel 0 has strict priority: if full[0], grant = 0 regardless of ptr, and ptr does not change.
  - Other channels use round robin among themselves.
- When undefined: pure round robin across all channels as above.

Test Plan:
- Test setup for all scenarios:
  - Shared stage is the team rounding unit with ACC_FRAC=32 and OUT_FRAC=15.
  - For the saturation-counter scenario, a flag stub drives rnd_ovf.
- Single word: ch2 sends 0x00_4000_0000 (0.25) at edge 0 -> out_valid after edge 1, out_data = 0x2000, out_ch = 2, flags 0, req_ready[2] stays 1.
- All 4 channels valid every cycle from reset, ptr = 0 -> out_ch sequence 0,1,2,3,0,1,... with no gaps; each req_ready[i] high exactly 1 cycle in 4.
- Back-to-back alone: ch1 streams 0.5, -0.5, 0.25 -> out_data 0x4000, 0xC000, 0x2000 on consecutive cycles; req_ready[1] stays 1.
- Saturation counters:
  - Stub rnd_ovf = 1 for 3 ch3 results, cnt_sel = 3 -> cnt_rdata = 3.
  - cnt_clr asserted in the same cycle as a 4th ovf result -> cnt_rdata = 0.
  - With CNT_WIDTH = 2, 5 ovf results -> cnt_rdata = 3.
- Reset mid-stream: assert rst while ch0 and ch1 are full -> outputs zero immediately, no out_valid after release, ptr = 0.
- With RND_SHARE_CH0_PRIO_EN: ch0, ch1 and ch2 valid continuously -> out_ch stays 0; drop ch0 -> out_ch alternates 1,2.

Source files
------------

// File: rtl/rnd_share_sched.sv
// rnd_share_sched: time-shares one combinational round/saturate stage among
// N_CH channels. Each channel has a one-entry hold register; a round-robin
// arbiter grants one held word per cycle to the stage, and the stage result
// is registered with its channel tag. Per-channel saturation events are
// counted in saturating counters.
//
// Optional build macro: RND_SHARE_CH0_PRIO_EN -- channel 0 gets strict
// priority over the round robin among the remaining channels.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_data/req_valid/req_ready  per-channel accumulator word handshake
//   rnd_data_in/rnd_valid_in      word presented to the shared stage
//   rnd_data_out/rnd_ovf/rnd_unf  combinational stage result and flags
//   out_data/out_valid/out_ch     registered result, pulse and channel tag
//   out_ovf/out_unf               registered stage flags
//   cnt_clr/cnt_sel/cnt_rdata     counter clear, read select, read data
module rnd_share_sched #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ACC_WIDTH = 42,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH*ACC_WIDTH-1:0]   req_data,
  input  logic [N_CH-1:0]             req_valid,
  output logic [N_CH-1:0]             req_ready,
  output logic [ACC_WIDTH-1:0]        rnd_data_in,
  output logic                        rnd_valid_in,
  input  logic [OUT_WIDTH-1:0]        rnd_data_out,
  input  logic                        rnd_ovf,
  input  logic                        rnd_unf,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  output logic [$clog2(N_CH)-1:0]     out_ch,
  output logic                        out_ovf,
  output logic                        out_unf,
  input  logic                        cnt_clr,
  input  logic [$clog2(N_CH)-1:0]     cnt_sel,
  output logic [CNT_WIDTH-1:0]        cnt_rdata
);

  localparam int unsigned CH_W = $clog2(N_CH);

  logic [ACC_WIDTH-1:0] hold [N_CH];
  logic [N_CH-1:0]      full;
  logic [CH_W-1:0]      ptr;
  logic [N_CH-1:0]      cand;
  logic [N_CH-1:0]      grant;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_any;
  logic                 rr_adv;
  int unsigned          arb_idx;
  logic [CNT_WIDTH-1:0] cnt [N_CH];

  // Arbiter: first full channel at or after ptr, with wrap-around.
  always_comb begin
    cand      = full;
    grant_idx = '0;
    grant_any = 1'b0;
    rr_adv    = 1'b0;
    arb_idx   = 0;
`ifdef RND_SHARE_CH0_PRIO_EN
    // Channel 0 preempts the round robin and leaves ptr untouched.
    if (full[0]) begin
      grant_any = 1'b1;
    end
    cand[0] = 1'b0;
`endif
    for (int unsigned k = 0; k < N_CH; k++) begin
      arb_idx = (32'(ptr) + k) % N_CH;
      if (!grant_any && cand[CH_W'(arb_idx)]) begin
        grant_any = 1'b1;
        rr_adv    = 1'b1;
        grant_idx = CH_W'(arb_idx);
      end
    end
    grant = N_CH'(grant_any) << grant_idx;
  end

  assign req_ready    = ~full | grant;
  assign rnd_valid_in = grant_any;
  assign rnd_data_in  = grant_any ? hold[grant_idx] : '0;
  assign cnt_rdata    = (32'(cnt_sel) < N_CH) ? cnt[cnt_sel] : '0;

  // Hold registers: reload on accept, empty on grant without accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      for (int unsigned i = 0; i < N_CH; i++) hold[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hold[i] <= req_data[i*ACC_WIDTH +: ACC_WIDTH];
          full[i] <= 1'b1;
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves past the channel it just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (rr_adv) begin
      ptr <= (32'(grant_idx) == N_CH - 1) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // Output register: capture the stage result on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_data <= rnd_data_out;
        out_ch   <= grant_idx;
        out_ovf  <= rnd_ovf;
        out_unf  <= rnd_unf;
      end
    end
  end

  // Saturation counters, counted at the edge the result is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cnt_clr) begin
          cnt[i] <= '0;
        end else if (grant[i] && (rnd_ovf || rnd_unf) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rnd_share_sched.sv
// Testbench for rnd_share_sched: directed scenarios plus a per-cycle
// comparison against a behavioural model of the scheduler.
module tb_rnd_share_sched;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned ACC_W = 42;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned CH_W  = 2;
`ifdef RND_SHARE_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam logic [ACC_W-1:0] W_QTR   = 42'h000_4000_0000;
  localparam logic [ACC_W-1:0] W_HALF  = 42'h000_8000_0000;
  localparam logic [ACC_W-1:0] W_MHALF = 42'h3FF_8000_0000;
  localparam logic [ACC_W-1:0] W_BIGP  = 42'h100_0000_0000;
  localparam logic [ACC_W-1:0] W_BIGN  = 42'h200_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [N_CH*ACC_W-1:0]   req_data;
  logic [N_CH-1:0]         req_valid;
  logic                    cnt_clr;
  logic [CH_W-1:0]         cnt_sel;
  logic                    force_ovf;

  logic [N_CH-1:0]  req_ready, req_ready2;
  logic [ACC_W-1:0] rnd_data_in, rnd_data_in2;
  logic             rnd_valid_in, rnd_valid_in2;
  logic [OUT_W-1:0] rnd_data_out, rnd_data_out2;
  logic             rnd_ovf, rnd_unf, rnd_ovf2, rnd_unf2;
  logic [OUT_W-1:0] out_data, out_data2;
  logic             out_valid, out_valid2, out_ovf, out_ovf2, out_unf, out_unf2;
  logic [CH_W-1:0]  out_ch, out_ch2;
  logic [15:0]      cnt_rdata;
  logic [1:0]       cnt_rdata2;

  rnd_share_sched u_dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .rnd_data_in(rnd_data_in), .rnd_valid_in(rnd_valid_in),
    .rnd_data_out(rnd_data_out), .rnd_ovf(rnd_ovf), .rnd_unf(rnd_unf),
    .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_ovf(out_ovf), .out_unf(out_unf), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata)
  );

  // Second instance with 2-bit counters to exercise counter saturation.
  rnd_share_sched #(.CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready2), .rnd_data_in(rnd_data_in2), .rnd_valid_in(rnd_valid_in2),
    .rnd_data_out(rnd_data_out2), .rnd_ovf(rnd_ovf2), .rnd_unf(rnd_unf2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ch(out_ch2),
    .out_ovf(out_ovf2), .out_unf(out_unf2), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata2)
  );

  // Rounding unit: Q.32 accumulator to Q.15 output, round half up, saturate.
  // Returns {data, ovf, unf}.
  function automatic logic [OUT_W+1:0] stage(input logic [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] s;
    longint v;
    logic [OUT_W-1:0] d;
    logic o, u;
    s = x;
    v = s;
    v = (v + 65536) >>> 17;
    o = 1'b0;
    u = 1'b0;
    if (v > 32767) begin
      d = 16'h7FFF; o = 1'b1;
    end else if (v < -32768) begin
      d = 16'h8000; u = 1'b1;
    end else begin
      d = v[15:0];
    end
    return {d, o, u};
  endfunction

  logic [OUT_W+1:0] st1, st2;
  assign st1 = stage(rnd_data_in);
  assign st2 = stage(rnd_data_in2);
  assign rnd_data_out  = st1[OUT_W+1:2];
  assign rnd_ovf       = st1[1] | force_ovf;
  assign rnd_unf       = st1[0];
  assign rnd_data_out2 = st2[OUT_W+1:2];
  assign rnd_ovf2      = st2[1] | force_ovf;
  assign rnd_unf2      = st2[0];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [ACC_W-1:0] m_hold [N_CH];
  bit               m_full [N_CH];
  int               m_ptr;
  logic [OUT_W-1:0] m_out_data;
  bit               m_out_valid, m_ovf, m_unf;
  int               m_out_ch;
  int               m_cnt [N_CH];
  int               cyc = 0;

  // Channel served this cycle, or -1 when nothing is waiting.
  function automatic int pick();
    if (PRIO && m_full[0]) return 0;
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (m_ptr + k) % N_CH;
      if (!(PRIO && c == 0) && m_full[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_out_data = '0; m_out_valid = 0; m_ovf = 0; m_unf = 0; m_out_ch = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_full[i] = 0; m_hold[i] = '0; m_cnt[i] = 0;
      end
    end else begin
      int g;
      logic [OUT_W+1:0] r;
      bit ready;
      g = pick();
      m_out_valid = (g >= 0);
      if (g >= 0) begin
        r = stage(m_hold[g]);
        m_out_data = r[OUT_W+1:2];
        m_ovf = r[1] | force_ovf;
        m_unf = r[0];
        m_out_ch = g;
        if (!(PRIO && g == 0)) m_ptr = (g + 1) % N_CH;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr) m_cnt[i] = 0;
        else if (g == i && (m_ovf || m_unf)) m_cnt[i]++;
      end
      for (int i = 0; i < N_CH; i++) begin
        ready = !m_full[i] || (g == i);
        if (req_valid[i] && ready) begin
          m_hold[i] = req_data[i*ACC_W +: ACC_W];
          m_full[i] = 1;
        end else if (g == i) begin
          m_full[i] = 0;
        end
      end
    end
  end

  // Observation logs for directed expectations.
  int              och_q [$];
  logic [OUT_W-1:0] od_q [$];
  logic [1:0]      of_q [$];
  int              oc_q [$];
  logic [N_CH-1:0] rdy_q [$];

  task automatic clear_logs();
    och_q.delete(); od_q.delete(); of_q.delete(); oc_q.delete(); rdy_q.delete();
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      begin
        int g, sel, c1, c2;
        logic [N_CH-1:0] er;
        logic [ACC_W-1:0] ed;
        g = pick();
        for (int i = 0; i < N_CH; i++) er[i] = !m_full[i] || (g == i);
        ed = (g >= 0) ? m_hold[g] : '0;
        sel = int'(cnt_sel);
        c1 = (m_cnt[sel] > 65535) ? 65535 : m_cnt[sel];
        c2 = (m_cnt[sel] > 3) ? 3 : m_cnt[sel];
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rnd_valid_in", 64'(rnd_valid_in), 64'(g >= 0));
        chk("rnd_data_in", 64'(rnd_data_in), 64'(ed));
        chk("out_valid", 64'(out_valid), 64'(m_out_valid));
        chk("out_data", 64'(out_data), 64'(m_out_data));
        chk("out_ch", 64'(out_ch), 64'(m_out_ch));
        chk("out_flags", 64'({out_ovf, out_unf}), 64'({m_ovf, m_unf}));
        chk("cnt_rdata", 64'(cnt_rdata), 64'(c1));
        chk("cnt_rdata_w2", 64'(cnt_rdata2), 64'(c2));
        rdy_q.push_back(req_ready);
        if (out_valid) begin
          och_q.push_back(int'(out_ch));
          od_q.push_back(out_data);
          of_q.push_back({out_ovf, out_unf});
          oc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_word(input int ch, input logic [ACC_W-1:0] d);
    req_data[ch*ACC_W +: ACC_W] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; cnt_clr = 1'b0; force_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int qch(input int i);
    return (i < och_q.size()) ? och_q[i] : -1;
  endfunction

  function automatic logic [OUT_W-1:0] qd(input int i);
    return (i < od_q.size()) ? od_q[i] : 16'hDEAD;
  endfunction

  initial begin
    int bad;
    rst = 1'b0; req_data = '0; req_valid = '0; cnt_clr = 1'b0;
    cnt_sel = '0; force_ovf = 1'b0;
    do_reset();
    @(negedge clk); #2;
    chk("reset_ready", 64'(req_ready), 64'hF);
    chk("reset_out_valid", 64'(out_valid), 64'h0);

    // Single word on ch2.
    @(negedge clk);
    clear_logs();
    set_word(2, W_QTR); req_valid = 4'b0100;
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    chk("single_count", 64'(och_q.size()), 64'd1);
    chk("single_ch", 64'(qch(0)), 64'd2);
    chk("single_data", 64'(qd(0)), 64'h2000);
    chk("single_flags", 64'(of_q.size() > 0 ? of_q[0] : 2'b11), 64'h0);
    bad = 0;
    foreach (rdy_q[i]) if (!rdy_q[i][2]) bad++;
    chk("single_ready2", 64'(bad), 64'd0);

    // All four channels streaming from reset.
    do_reset();
    for (int i = 0; i < N_CH; i++) set_word(i, 42'(i + 1) * 42'h000_2000_0000);
    clear_logs();
    req_valid = 4'b1111;
    repeat (12) @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    bad = 0;
    for (int i = 0; i < och_q.size(); i++) if (och_q[i] != i % 4) bad++;
    for (int i = 1; i < oc_q.size(); i++) if (oc_q[i] != oc_q[i-1] + 1) bad++;
    chk("rr_order_gaps", 64'(bad), 64'd0);
    chk("rr_count", 64'(och_q.size() >= 12), 64'd1);
    chk("rr_first_data", 64'(qd(0)), 64'h1000);
    bad = 0;
    for (int i = 1; i <= 8; i++) if ($countones(rdy_q[i]) != 1) bad++;
    chk("rr_ready_onehot", 64'(bad), 64'd0);

    // Back-to-back on ch1 alone.
    @(negedge clk);
    clear_logs();
    set_word(1, W_HALF); req_valid = 4'b0010;
    @(negedge clk); set_word(1, W_MHALF);
    @(negedge clk); set_word(1, W_QTR);
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    chk("b2b_d0", 64'(qd(0)), 64'h4000);
    chk("b2b_d1", 64'(qd(1)), 64'hC000);
    chk("b2b_d2", 64'(qd(2)), 64'h2000);
    chk("b2b_consecutive", 64'(oc_q.size() == 3 && oc_q[2] == oc_q[0] + 2), 64'd1);
    bad = 0;
    foreach (rdy_q[i]) if (!rdy_q[i][1]) bad++;
    chk("b2b_ready1", 64'(bad), 64'd0);

    // Saturation counters via the ovf stub on ch3.
    do_reset();
    force_ovf = 1'b1; cnt_sel = 2'd3;
    set_word(3, W_QTR); req_valid = 4'b1000;
    repeat (3) @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk); #2;
    chk("cnt_three", 64'(cnt_rdata), 64'd3);
    chk("cnt_three_w2", 64'(cnt_rdata2), 64'd3);
    @(negedge clk); req_valid = 4'b1000;
    @(negedge clk); req_valid = '0; cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; #2;
    chk("clr_wins_valid", 64'(out_valid && out_ovf), 64'd1);
    chk("clr_wins_cnt", 64'(cnt_rdata), 64'd0);
    @(negedge clk); req_valid = 4'b1000;
    repeat (5) @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk); #2;
    chk("cnt_five", 64'(cnt_rdata), 64'd5);
    chk("cnt_sat_w2", 64'(cnt_rdata2), 64'd3);

    // Real saturation from the rounding unit on ch0.
    @(negedge clk);
    force_ovf = 1'b0; cnt_sel = 2'd0; clear_logs();
    set_word(0, W_BIGP); req_valid = 4'b0001;
    @(negedge clk); set_word(0, W_BIGN);
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk); #2;
    chk("sat_pos", 64'(qd(0)), 64'h7FFF);
    chk("sat_pos_flags", 64'(of_q.size() > 0 ? of_q[0] : 2'b00), 64'h2);
    chk("sat_neg", 64'(qd(1)), 64'h8000);
    chk("sat_neg_flags", 64'(of_q.size() > 1 ? of_q[1] : 2'b00), 64'h1);
    chk("sat_cnt0", 64'(cnt_rdata), 64'd2);

    // Reset while ch0 and ch1 hold words, with ptr moved off zero.
    do_reset();
    set_word(1, W_QTR); req_valid = 4'b0010;
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    set_word(0, W_HALF); set_word(1, W_HALF); req_valid = 4'b0011;
    @(negedge clk); req_valid = '0; rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_rnd_valid", 64'(rnd_valid_in), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'hF);
    repeat (2) @(negedge clk);
    rst = 1'b0; clear_logs();
    repeat (4) @(negedge clk);
    chk("rst_no_output", 64'(och_q.size()), 64'd0);
    set_word(1, W_QTR); set_word(3, W_QTR); req_valid = 4'b1010;
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
    chk("rst_ptr_first", 64'(qch(0)), 64'd1);
    chk("rst_ptr_second", 64'(qch(1)), 64'd3);

`ifdef RND_SHARE_CH0_PRIO_EN
    // Strict channel-0 priority.
    do_reset();
    for (int i = 0; i < 3; i++) set_word(i, W_QTR);
    clear_logs();
    req_valid = 4'b0111;
    repeat (8) @(negedge clk);
    bad = 0;
    foreach (och_q[i]) if (och_q[i] != 0) bad++;
    chk("prio_only_ch0", 64'(bad), 64'd0);
    chk("prio_count", 64'(och_q.size() >= 6), 64'd1);
    clear_logs();
    req_valid = 4'b0110;
    repeat (6) @(negedge clk);
    chk("prio_drop0", 64'(qch(0)), 64'd0);
    chk("prio_alt1", 64'(qch(1)), 64'd1);
    chk("prio_alt2", 64'(qch(2)), 64'd2);
    chk("prio_alt3", 64'(qch(3)), 64'd1);
    chk("prio_alt4", 64'(qch(4)), 64'd2);
    req_valid = '0;
    repeat (4) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
